sdram_line_buffer: RTL and testbench
====================================

# sdram_line_buffer

Single-line write-back buffer between a 16-bit word-oriented master (CPU/bus) and the 128-bit line port of the SDRAM controller. It holds one 8-word line (tag, valid, dirty). Word accesses that hit the line are served locally. A miss writes the line back if it is dirty, then fills it from SDRAM using the controller's write/read req/ack handshakes. It also provides an explicit flush for coherency before reset or DMA.

## Interface
- No parameters; fixed geometry: 22-bit line address, 8 × 16-bit words per line.
- iclk  in  1  system clock, same domain as the SDRAM controller.
- ireset_n  in  1  asynchronous, active-low reset.
- icpu_req  in  1  word access request; held with addr/we/wdata until ocpu_ack.
- icpu_we  in  1  1 = write, 0 = read.
- icpu_addr  in  25  word address: [24:3] line address, [2:0] word index.
- icpu_wdata  in  16  write data.
- ocpu_rdata  out  16  read data, valid when ocpu_ack=1.
- ocpu_ack  out  1  one-cycle completion pulse.
- iflush  in  1  flush request; held until oflush_ack.
- oflush_ack  out  1  one-cycle pulse when the line is clean.
- owrite_req  out  1  line write request to the controller.
- owrite_address  out  22  line address of the write-back (= stored tag).
- owrite_data  out  128  line data; word i at bits [16i+15:16i].
- iwrite_ack  in  1  controller write-done pulse.
- oread_req  out  1  line fill request to the controller.
- oread_address  out  22  icpu_addr[24:3] of the missing access.
- iread_data  in  128  fill data, valid in the iread_ack cycle.
- iread_ack  in  1  controller read-done pulse.

## Operation
- Storage: line[127:0], tag[21:0], valid, dirty.
- States: IDLE, WB (write-back), FILL, RESP, FACK (flush ack).
- IDLE, icpu_req=1, valid and tag==icpu_addr[24:3] (hit):
  - Read: ocpu_rdata ← word[idx].
  - Write: word[idx] ← icpu_wdata, dirty ← 1.
  - Next state RESP.
- IDLE, icpu_req=1, miss:
  - dirty=1 → WB.
  - dirty=0 → FILL.
- WB:
  - owrite_address=tag, owrite_data=line.
  - On iwrite_ack: dirty ← 0. Next state FILL for a CPU miss, FACK for a flush.
- FILL:
  - oread_address=icpu_addr[24:3].
  - On iread_ack: line ← iread_data, tag ← address, valid ← 1, then serve the access as a hit in the same edge: read captures word[idx] from iread_data; write merges icpu_wdata and sets dirty=1. Next state RESP.
- RESP: ocpu_ack=1 for one cycle; next state IDLE.
- Flush in IDLE:
  - dirty=1 → WB.
  - dirty=0 → FACK.
  - FACK asserts oflush_ack for one cycle, then IDLE. The line stays valid.
- Simultaneous icpu_req and iflush in IDLE: CPU access wins. The flush is taken on a later IDLE cycle.
- icpu_req and iflush are ignored in every state except IDLE.

## Timing
- Reset (asynchronous, active-low): state=IDLE, valid=0, dirty=0, tag=0, line=0. All outputs are 0: ocpu_ack, ocpu_rdata, oflush_ack, owrite_req, oread_req, owrite_address, owrite_data, oread_address.
- Reset during WB or FILL aborts the transfer. Dirty data is lost; this is by design, since the SDRAM controller is reset on the same event.
- Memory-side handshake (required by the controller, which re-samples req in its idle cycle):
  - owrite_req = (state==WB) & ~iwrite_ack.
  - oread_req = (state==FILL) & ~iread_ack.
  - Each req is deasserted combinationally in its ack cycle, so the controller never sees a duplicate request.
  - Address and data are registered and stable for the entire time req is high.
- Hit latency: request in IDLE at cycle 0, ocpu_ack at cycle 1. Maximum throughput is one access per 2 cycles.
- Clean-miss latency: 1 + fill cycles + 1. Dirty-miss latency adds the write-back handshake. Clean miss: FILL is entered at cycle 1.
- ocpu_rdata holds its value after ack until the next read completes.
- The master must drop or change its request in the cycle after ack.

## Test plan
- Cold read: after reset, read addr 0x0000010 → oread_req with oread_address=0x000002. Return iread_data = words 0..7 = 0x1000..0x1007 with iread_ack → ocpu_ack, ocpu_rdata=0x1000. owrite_req never asserted.
- Hit read/write: write 0xBEEF to 0x0000013, then read 0x0000013 → each ack arrives 1 cycle after req; rdata=0xBEEF; no memory requests.
- Dirty miss: after the above, read 0x0000400 → owrite_req with owrite_address=0x000002 and owrite_data word3=0xBEEF. Then oread_address=0x000080. owrite_req drops in the iwrite_ack cycle.
- Flush: dirty line, assert iflush → one write-back, then oflush_ack pulse. A second iflush gives oflush_ack 1 cycle later with no owrite_req.
- Write miss merge: clean line, write 0x1234 to 0x0000809 with fill data all 0xAAAA → after ack, read 0x0000809 = 0x1234 and read 0x0000808 = 0xAAAA. dirty=1, checked by a following flush that writes back.
- Reset mid-FILL: deassert ireset_n while oread_req=1 → all outputs 0 immediately. The next access to the same address misses and fills again.

Source files
------------

// File: rtl/sdram_line_buffer.sv
// Single-line write-back buffer between a 16-bit word master and the 128-bit line
// port of the SDRAM controller: one 8-word line with tag, valid and dirty bits.
module sdram_line_buffer (
  input  logic         iclk,
  input  logic         ireset_n,
  input  logic         icpu_req,
  input  logic         icpu_we,
  input  logic [24:0]  icpu_addr,
  input  logic [15:0]  icpu_wdata,
  output logic [15:0]  ocpu_rdata,
  output logic         ocpu_ack,
  input  logic         iflush,
  output logic         oflush_ack,
  output logic         owrite_req,
  output logic [21:0]  owrite_address,
  output logic [127:0] owrite_data,
  input  logic         iwrite_ack,
  output logic         oread_req,
  output logic [21:0]  oread_address,
  input  logic [127:0] iread_data,
  input  logic         iread_ack
);

  typedef enum logic [2:0] {IDLE, WB, FILL, RESP, FACK} state_t;

  state_t         state_q, state_d;
  logic [127:0]   line_q, line_d;
  logic [21:0]    tag_q, tag_d;
  logic           valid_q, valid_d;
  logic           dirty_q, dirty_d;
  logic [15:0]    rdata_q, rdata_d;
  logic [21:0]    rdAddr_q, rdAddr_d;
  logic           wbFlush_q, wbFlush_d;

  logic [2:0]     wordIdx;
  logic [6:0]     bitBase;
  logic [21:0]    reqLine;
  logic           hit;

  assign wordIdx = icpu_addr[2:0];
  assign bitBase = {wordIdx, 4'b0000};
  assign reqLine = icpu_addr[24:3];
  assign hit     = valid_q && (tag_q == reqLine);

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q   <= IDLE;
      line_q    <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      dirty_q   <= 1'b0;
      rdata_q   <= '0;
      rdAddr_q  <= '0;
      wbFlush_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      rdata_q   <= rdata_d;
      rdAddr_q  <= rdAddr_d;
      wbFlush_q <= wbFlush_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    rdata_d   = rdata_q;
    rdAddr_d  = rdAddr_q;
    wbFlush_d = wbFlush_q;
    unique case (state_q)
      IDLE: begin
        // CPU access has priority; a held flush is picked up on a later IDLE cycle
        if (icpu_req) begin
          if (hit) begin
            if (icpu_we) begin
              line_d[bitBase +: 16] = icpu_wdata;
              dirty_d = 1'b1;
            end else begin
              rdata_d = line_q[bitBase +: 16];
            end
            state_d = RESP;
          end else begin
            rdAddr_d  = reqLine;
            wbFlush_d = 1'b0;
            state_d   = dirty_q ? WB : FILL;
          end
        end else if (iflush) begin
          wbFlush_d = 1'b1;
          state_d   = dirty_q ? WB : FACK;
        end
      end
      WB: begin
        if (iwrite_ack) begin
          dirty_d = 1'b0;
          state_d = wbFlush_q ? FACK : FILL;
        end
      end
      FILL: begin
        // The fill edge also completes the pending access as if it had hit
        if (iread_ack) begin
          line_d  = iread_data;
          tag_d   = rdAddr_q;
          valid_d = 1'b1;
          if (icpu_we) begin
            line_d[bitBase +: 16] = icpu_wdata;
            dirty_d = 1'b1;
          end else begin
            rdata_d = iread_data[bitBase +: 16];
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      FACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requests drop combinationally in their ack cycle so the controller never re-samples them
  assign owrite_req     = (state_q == WB) && !iwrite_ack;
  assign oread_req      = (state_q == FILL) && !iread_ack;
  assign owrite_address = tag_q;
  assign owrite_data    = line_q;
  assign oread_address  = rdAddr_q;
  assign ocpu_ack       = (state_q == RESP);
  assign oflush_ack     = (state_q == FACK);
  assign ocpu_rdata     = rdata_q;

endmodule

// File: tb/tb_sdram_line_buffer.sv
// Directed, table-driven bench for sdram_line_buffer with a bounded memory-side
// responder; expected values in the vector table are worked out by hand.
module tb_sdram_line_buffer;

  logic         iclk = 1'b0;
  logic         ireset_n;
  logic         icpu_req;
  logic         icpu_we;
  logic [24:0]  icpu_addr;
  logic [15:0]  icpu_wdata;
  logic [15:0]  ocpu_rdata;
  logic         ocpu_ack;
  logic         iflush;
  logic         oflush_ack;
  logic         owrite_req;
  logic [21:0]  owrite_address;
  logic [127:0] owrite_data;
  logic         iwrite_ack;
  logic         oread_req;
  logic [21:0]  oread_address;
  logic [127:0] iread_data;
  logic         iread_ack;

  int nChecks = 0;
  int nFails  = 0;

  always #5 iclk = ~iclk;

  sdram_line_buffer dut (
    .iclk(iclk), .ireset_n(ireset_n),
    .icpu_req(icpu_req), .icpu_we(icpu_we), .icpu_addr(icpu_addr),
    .icpu_wdata(icpu_wdata), .ocpu_rdata(ocpu_rdata), .ocpu_ack(ocpu_ack),
    .iflush(iflush), .oflush_ack(oflush_ack),
    .owrite_req(owrite_req), .owrite_address(owrite_address),
    .owrite_data(owrite_data), .iwrite_ack(iwrite_ack),
    .oread_req(oread_req), .oread_address(oread_address),
    .iread_data(iread_data), .iread_ack(iread_ack)
  );

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_FL} op_t;

  typedef struct {
    op_t          op;
    logic [24:0]  addr;
    logic [15:0]  wdata;
    logic [127:0] fill;
    logic         expWb;
    logic [21:0]  expWbAddr;
    logic [127:0] expWbData;
    logic         expRd;
    logic [21:0]  expRdAddr;
    logic [15:0]  expRdata;
    int           expLat;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cpu_ack"},   ocpu_ack,       0);
    checkOutput({tag, "_rdata"},     ocpu_rdata,     0);
    checkOutput({tag, "_flush_ack"}, oflush_ack,     0);
    checkOutput({tag, "_wreq"},      owrite_req,     0);
    checkOutput({tag, "_rreq"},      oread_req,      0);
    checkOutput({tag, "_waddr"},     owrite_address, 0);
    checkOutput({tag, "_wdata"},     owrite_data,    0);
    checkOutput({tag, "_raddr"},     oread_address,  0);
  endtask

  // Issues one CPU access or flush and services memory requests (ack after 2 cycles of req)
  task automatic applyStimulus(input vec_t v, input int n);
    int    cyc = 0;
    int    wbWait = 0;
    int    rdWait = 0;
    bit    wbSeen = 0;
    bit    rdSeen = 0;
    bit    done = 0;
    string id = $sformatf("v%0d", n);
    @(posedge iclk); #1;
    if (v.op == OP_FL) iflush = 1'b1;
    else begin
      icpu_req   = 1'b1;
      icpu_we    = (v.op == OP_WR);
      icpu_addr  = v.addr;
      icpu_wdata = v.wdata;
    end
    while (!done && cyc < 100) begin
      @(posedge iclk); #1;
      iwrite_ack = 1'b0;
      iread_ack  = 1'b0;
      cyc++;
      if ((v.op == OP_FL) ? oflush_ack : ocpu_ack) begin
        done = 1;
        checkOutput({id, "_latency"}, cyc, v.expLat);
        if (v.op == OP_RD) checkOutput({id, "_rdata"}, ocpu_rdata, v.expRdata);
        icpu_req = 1'b0;
        iflush   = 1'b0;
      end else if (owrite_req) begin
        if (!wbSeen) begin
          checkOutput({id, "_wb_addr"}, owrite_address, v.expWbAddr);
          checkOutput({id, "_wb_data"}, owrite_data, v.expWbData);
        end
        wbSeen = 1;
        wbWait++;
        if (wbWait == 2) begin
          iwrite_ack = 1'b1;
          #1 checkOutput({id, "_wreq_drop"}, owrite_req, 0);
        end
      end else if (oread_req) begin
        if (!rdSeen) checkOutput({id, "_rd_addr"}, oread_address, v.expRdAddr);
        rdSeen = 1;
        rdWait++;
        if (rdWait == 2) begin
          iread_data = v.fill;
          iread_ack  = 1'b1;
          #1 checkOutput({id, "_rreq_drop"}, oread_req, 0);
        end
      end
    end
    checkOutput({id, "_completed"}, done, 1);
    checkOutput({id, "_wb_seen"}, wbSeen, v.expWb);
    checkOutput({id, "_rd_seen"}, rdSeen, v.expRd);
    icpu_req = 1'b0;
    iflush   = 1'b0;
    @(posedge iclk); #1;
    iwrite_ack = 1'b0;
    iread_ack  = 1'b0;
    checkOutput({id, "_ack_pulse"}, (v.op == OP_FL) ? oflush_ack : ocpu_ack, 0);
    if (v.op == OP_RD) checkOutput({id, "_rdata_hold"}, ocpu_rdata, v.expRdata);
  endtask

  initial begin
    bit got;
    ireset_n   = 1'b0;
    icpu_req   = 1'b0;
    icpu_we    = 1'b0;
    icpu_addr  = '0;
    icpu_wdata = '0;
    iflush     = 1'b0;
    iwrite_ack = 1'b0;
    iread_ack  = 1'b0;
    iread_data = '0;

    vecs[0]  = '{OP_RD, 25'h0000010, 16'h0, 128'h1007_1006_1005_1004_1003_1002_1001_1000,
                 0, 22'h0, 128'h0, 1, 22'h000002, 16'h1000, 3};
    vecs[1]  = '{OP_WR, 25'h0000013, 16'hBEEF, 128'h0, 0, 22'h0, 128'h0, 0, 22'h0, 16'h0, 1};
    vecs[2]  = '{OP_RD, 25'h0000013, 16'h0, 128'h0, 0, 22'h0, 128'h0, 0, 22'h0, 16'hBEEF, 1};
    vecs[3]  = '{OP_RD, 25'h0000400, 16'h0, 128'h2007_2006_2005_2004_2003_2002_2001_2000,
                 1, 22'h000002, 128'h1007_1006_1005_1004_BEEF_1002_1001_1000,
                 1, 22'h000080, 16'h2000, 5};
    vecs[4]  = '{OP_RD, 25'h0000405, 16'h0, 128'h0, 0, 22'h0, 128'h0, 0, 22'h0, 16'h2005, 1};
    vecs[5]  = '{OP_FL, 25'h0, 16'h0, 128'h0, 0, 22'h0, 128'h0, 0, 22'h0, 16'h0, 1};
    vecs[6]  = '{OP_WR, 25'h0000809, 16'h1234, {8{16'hAAAA}}, 0, 22'h0, 128'h0, 1, 22'h000101, 16'h0, 3};
    vecs[7]  = '{OP_RD, 25'h0000809, 16'h0, 128'h0, 0, 22'h0, 128'h0, 0, 22'h0, 16'h1234, 1};
    vecs[8]  = '{OP_RD, 25'h0000808, 16'h0, 128'h0, 0, 22'h0, 128'h0, 0, 22'h0, 16'hAAAA, 1};
    vecs[9]  = '{OP_FL, 25'h0, 16'h0, 128'h0, 1, 22'h000101,
                 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_1234_AAAA, 0, 22'h0, 16'h0, 3};
    vecs[10] = '{OP_FL, 25'h0, 16'h0, 128'h0, 0, 22'h0, 128'h0, 0, 22'h0, 16'h0, 1};
    vecs[11] = '{OP_RD, 25'h000080F, 16'h0, 128'h0, 0, 22'h0, 128'h0, 0, 22'h0, 16'hAAAA, 1};

    #12;
    checkAllZero("reset");
    ireset_n = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // CPU access and flush together: access acks first, flush completes afterwards
    @(posedge iclk); #1;
    icpu_req  = 1'b1;
    icpu_we   = 1'b0;
    icpu_addr = 25'h0000809;
    iflush    = 1'b1;
    @(posedge iclk); #1;
    checkOutput("both_cpu_ack", ocpu_ack, 1);
    checkOutput("both_flush_ack_early", oflush_ack, 0);
    checkOutput("both_rdata", ocpu_rdata, 16'h1234);
    icpu_req = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge iclk); #1;
      checkOutput("both_no_wreq", owrite_req, 0);
      if (oflush_ack) got = 1;
    end
    checkOutput("both_flush_done", got, 1);
    iflush = 1'b0;

    // Reset while a fill is outstanding aborts it; the line must be refetched
    @(posedge iclk); #1;
    icpu_req  = 1'b1;
    icpu_we   = 1'b0;
    icpu_addr = 25'h0002000;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge iclk); #1;
      if (oread_req) got = 1;
    end
    checkOutput("rst_fill_reached", got, 1);
    checkOutput("rst_fill_addr", oread_address, 22'h000400);
    #1 ireset_n = 1'b0;
    #1 checkAllZero("midfill_rst");
    icpu_req = 1'b0;
    #4 ireset_n = 1'b1;
    applyStimulus('{OP_RD, 25'h0002000, 16'h0, 128'h3007_3006_3005_3004_3003_3002_3001_3000,
                    0, 22'h0, 128'h0, 1, 22'h000400, 16'h3000, 3}, 12);
    applyStimulus('{OP_RD, 25'h0000808, 16'h0, 128'h5557_5556_5555_5554_5553_5552_5551_5550,
                    0, 22'h0, 128'h0, 1, 22'h000101, 16'h5550, 3}, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
